// File: rtl/fetch_if.sv
// Instruction-memory req/ack channel between the fetch stage and instruction memory.
interface fetch_if;
  logic        con_ImemReq;
  logic [31:0] addr_Imem;
  logic        con_ImemAck;
  logic [31:0] data_Imem;

  modport master (output con_ImemReq, addr_Imem, input con_ImemAck, data_Imem);
  modport slave  (input con_ImemReq, addr_Imem, output con_ImemAck, data_Imem);
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// drives the IF/ID pipeline register, handling stalls and MEM-stage redirects.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_con_Stall,
  input  logic        i_con_PCSrc,
  input  logic [31:0] i_addr_Branch,
  fetch_if.master     imem,
  output logic [31:0] o_data_Instr,
  output logic [31:0] o_addr_NextPC,
  output logic        o_con_Valid
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  logic [31:0] r_addr, w_addr_n;
  logic [31:0] r_skid, w_skid_n;
  logic [31:0] r_instr, w_instr_n;
  logic [31:0] r_nextpc, w_nextpc_n;
  logic        r_valid, w_valid_n;
  logic [31:0] w_pc4;

  assign w_pc4 = r_pc + 32'd4;

  // Request outputs come from state/registers only; DRAIN keeps presenting the
  // abandoned address until memory acknowledges it.
  assign imem.con_ImemReq = (r_state != HOLD);
  assign imem.addr_Imem   = (r_state == DRAIN) ? r_addr : r_pc;

  assign o_data_Instr  = r_instr;
  assign o_addr_NextPC = r_nextpc;
  assign o_con_Valid   = r_valid;

  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_addr_n   = r_addr;
    w_skid_n   = r_skid;
    w_instr_n  = r_instr;
    w_nextpc_n = r_nextpc;
    w_valid_n  = r_valid;
    if (i_con_PCSrc) begin
      w_pc_n    = {i_addr_Branch[31:2], 2'b00};
      w_instr_n = NOP_INSTR;
      w_valid_n = 1'b0;
      case (r_state)
        FETCH: begin
          if (!imem.con_ImemAck) begin
            w_state_n = DRAIN;
            w_addr_n  = r_pc;
          end
        end
        HOLD:    w_state_n = FETCH;
        default: w_state_n = DRAIN;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (imem.con_ImemAck) begin
            if (!i_con_Stall) begin
              w_instr_n  = imem.data_Imem;
              w_nextpc_n = w_pc4;
              w_valid_n  = 1'b1;
              w_pc_n     = w_pc4;
            end else begin
              w_skid_n  = imem.data_Imem;
              w_state_n = HOLD;
            end
          end else if (!i_con_Stall) begin
            w_instr_n = NOP_INSTR;
            w_valid_n = 1'b0;
          end
        end
        HOLD: begin
          if (!i_con_Stall) begin
            w_instr_n  = r_skid;
            w_nextpc_n = w_pc4;
            w_valid_n  = 1'b1;
            w_pc_n     = w_pc4;
            w_state_n  = FETCH;
          end
        end
        default: begin
          if (imem.con_ImemAck) w_state_n = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_addr   <= RESET_PC;
      r_skid   <= '0;
      r_instr  <= NOP_INSTR;
      r_nextpc <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pc     <= w_pc_n;
      r_addr   <= w_addr_n;
      r_skid   <= w_skid_n;
      r_instr  <= w_instr_n;
      r_nextpc <= w_nextpc_n;
      r_valid  <= w_valid_n;
    end
  end

endmodule
